mapper_mmc1: RTL and testbench
==============================

Name: mapper_mmc1

Overview:
- MMC1 (mapper №1) bank controller for the cartridge.
- Captures CPU writes to $8000-$FFFF through the MMC1 5-bit serial load port into four internal registers: control, CHR bank 0, CHR bank 1, PRG bank.
- Translates CPU/PPU cartridge addresses into extended PRG ROM / PRG RAM / CHR memory addresses and selects the nametable layout.
- Sits beside the other mappers in the cartridge block; the cartridge mux picks its outputs when the mapper number is 1.

Parameters:
- None. The PRG ROM size arrives at run time on prg_last_bank_i.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- cpu_cycle_en_i  in  1  one-clk strobe marking each CPU bus cycle
- prg_rom_wr_i  in  1  CPU write to $8000-$FFFF in this CPU cycle; qualified by cpu_cycle_en_i
- cpu_data_i  in  8  CPU write data
- prg_last_bank_i  in  4  index of the last 16 KiB PRG bank (ROM size / 16 KiB − 1)
- prg_rom_addr_i  in  15  CPU address bits [14:0], $8000-$FFFF
- prg_ram_addr_i  in  13  CPU address into $6000-$7FFF
- chr_mem_addr_i  in  13  PPU address $0000-$1FFF
- mmc1_prg_rom_addr_o  out  19  extended PRG ROM address
- mmc1_prg_ram_addr_o  out  15  extended PRG RAM address
- mmc1_prg_ram_en_o  out  1  PRG RAM access enabled
- mmc1_chr_mem_addr_o  out  18  extended CHR address
- mmc1_nametable_layout_o  out  3  nametable layout code

Behaviour:
- One clock domain (clk_i). Reset is asynchronous and active-low (rst_n_i). All state changes only on a clk_i edge where cpu_cycle_en_i=1.
- Reset values:
  - shift register 0, write count 0, wr_prev 0
  - control = 5'b01100 (PRG mode 3, CHR 8K, one-screen lower)
  - chr_bank0 = 0, chr_bank1 = 0, prg_bank = 0
- Reset values of the outputs follow from these registers through the translation rules below.
- Write acceptance: a write is accepted when cpu_cycle_en_i & prg_rom_wr_i & !wr_prev.
  - wr_prev <= prg_rom_wr_i at every cpu_cycle_en_i strobe.
  - A write in the CPU cycle immediately after any write (RMW double write) is ignored entirely.
- Accepted write with cpu_data_i[7]=1:
  - shift register and count cleared
  - control[3:2] <= 2'b11; other control bits and all other registers unchanged
- Accepted write with cpu_data_i[7]=0:
  - cpu_data_i[0] is shifted in LSB-first; count increments.
  - On the fifth write (count==4), the 5-bit value {d0_w5, shift[3:0]} goes to the register selected by prg_rom_addr_i[14:13] of that fifth write: 0 control, 1 chr_bank0, 2 chr_bank1, 3 prg_bank.
  - The shift register and count are cleared in the same edge.
- Address translation is purely combinational from the registers: zero latency, and a new register value takes effect the clk after its capture edge.
- PRG ROM, 16 KiB bank b → {1'b0, b[3:0], prg_rom_addr_i[13:0]}:
  - mode 0/1: b = {prg_bank[3:1], prg_rom_addr_i[14]}
  - mode 2: $8000 → b = 0; $C000 → b = prg_bank[3:0]
  - mode 3: $8000 → b = prg_bank[3:0]; $C000 → b = prg_last_bank_i
- PRG RAM:
  - mmc1_prg_ram_addr_o = {2'b00, prg_ram_addr_i}
  - mmc1_prg_ram_en_o = ~prg_bank[4]
- CHR:
  - control[4]=0 (8K): {1'b0, chr_bank0[4:1], chr_mem_addr_i[12:0]}
  - control[4]=1 (4K): {1'b0, (chr_mem_addr_i[12] ? chr_bank1 : chr_bank0), chr_mem_addr_i[11:0]}
- Nametable layout from control[1:0]:
  - 0 → NAMETABLE_LAYOUT_SINGLE_SCREEN_LOWER
  - 1 → NAMETABLE_LAYOUT_SINGLE_SCREEN_UPPER
  - 2 → NAMETABLE_LAYOUT_VERTICAL_MIRRORING
  - 3 → NAMETABLE_LAYOUT_HORIZONTAL_MIRRORING
- Boundary conditions:
  - Reset asserted mid-sequence discards the partial shift immediately.
  - A bit7 write on the fifth position clears the shift and commits nothing.
  - prg_rom_wr_i without cpu_cycle_en_i is ignored.

Decomposition:
- Layout codes live in the shared localparam_nametable_layout.vh.
- Register indices and PRG mode codes are added there or to a new localparam_mmc1.vh.
- One sub-module is natural: mmc1_serial_port (wr_prev filter, shift register, count). It outputs a 1-clk commit strobe, 2-bit register index, 5-bit value and a reset strobe.

Test Plan:
- Reset → prg mode 3. prg_rom_addr_i=15'h4000 with prg_last_bank_i=4'hF → prg_rom_addr_o=19'h3C000; layout SINGLE_SCREEN_LOWER; prg_ram_en_o=1.
- Five spaced writes of bits 0,1,0,0,0 to $8000 → control=5'h02 → layout VERTICAL the clk after the fifth write.
- Three writes, then data 8'h80, then five writes of 1 to $E000 → prg_bank=5'h1F; prg_ram_en_o=0; $8000 maps to 19'h3C000.
- Two writes on consecutive CPU cycles → the second is ignored; the sequence needs 6 CPU cycles with one skipped, and the committed value matches the non-ignored bits.
- control=5'h10, chr_bank0=5, chr_bank1=9 → chr_mem_addr_i=13'h0123 gives 18'h05123; chr_mem_addr_i=13'h1123 gives 18'h09123.
- prg mode 2 with prg_bank=3 → $8000 gives 19'h00000; $C000+5 gives 19'h0C005.

Source files
------------

// File: rtl/mapper_mmc1_pkg.sv
// Shared constants and types for the MMC1 bank controller: nametable layout
// codes, serial-port register indices and PRG banking modes.
package mapper_mmc1_pkg;

    // Nametable layout codes driven to the cartridge/PPU nametable logic.
    localparam logic [2:0] NAMETABLE_LAYOUT_HORIZONTAL_MIRRORING = 3'd0;
    localparam logic [2:0] NAMETABLE_LAYOUT_VERTICAL_MIRRORING   = 3'd1;
    localparam logic [2:0] NAMETABLE_LAYOUT_SINGLE_SCREEN_LOWER  = 3'd2;
    localparam logic [2:0] NAMETABLE_LAYOUT_SINGLE_SCREEN_UPPER  = 3'd3;

    // Internal register selected by CPU address bits [14:13] of the fifth write.
    typedef enum logic [1:0] {
        REG_CONTROL   = 2'd0,
        REG_CHR_BANK0 = 2'd1,
        REG_CHR_BANK1 = 2'd2,
        REG_PRG_BANK  = 2'd3
    } mmc1_reg_e;

    // PRG banking mode held in control[3:2].
    typedef enum logic [1:0] {
        PRG_MODE_32K_0     = 2'd0,
        PRG_MODE_32K_1     = 2'd1,
        PRG_MODE_FIX_FIRST = 2'd2,
        PRG_MODE_FIX_LAST  = 2'd3
    } prg_mode_e;

    // Power-on control: PRG mode 3, 8 KiB CHR, one-screen lower.
    localparam logic [4:0] CONTROL_RESET = 5'b01100;

    // Maps control[1:0] mirroring bits to a nametable layout code.
    function automatic logic [2:0] layout_from_mirroring(input logic [1:0] mirroring);
        case (mirroring)
            2'd0:    return NAMETABLE_LAYOUT_SINGLE_SCREEN_LOWER;
            2'd1:    return NAMETABLE_LAYOUT_SINGLE_SCREEN_UPPER;
            2'd2:    return NAMETABLE_LAYOUT_VERTICAL_MIRRORING;
            default: return NAMETABLE_LAYOUT_HORIZONTAL_MIRRORING;
        endcase
    endfunction

endpackage

// File: rtl/mapper_mmc1_if.sv
// Cartridge-side bus of the MMC1: CPU/PPU address and write inputs plus the
// translated memory addresses and nametable layout it produces.
interface mapper_mmc1_if;
    import mapper_mmc1_pkg::*;

    logic        cpu_cycle_en;
    logic        prg_rom_wr;
    logic [7:0]  cpu_data;
    logic [3:0]  prg_last_bank;
    logic [14:0] prg_rom_addr;
    logic [12:0] prg_ram_addr;
    logic [12:0] chr_mem_addr;

    logic [18:0] mmc1_prg_rom_addr;
    logic [14:0] mmc1_prg_ram_addr;
    logic        mmc1_prg_ram_en;
    logic [17:0] mmc1_chr_mem_addr;
    logic [2:0]  mmc1_nametable_layout;

    // Cartridge bus / CPU side.
    modport master (
        output cpu_cycle_en, prg_rom_wr, cpu_data, prg_last_bank,
               prg_rom_addr, prg_ram_addr, chr_mem_addr,
        input  mmc1_prg_rom_addr, mmc1_prg_ram_addr, mmc1_prg_ram_en,
               mmc1_chr_mem_addr, mmc1_nametable_layout
    );

    // Mapper side.
    modport slave (
        input  cpu_cycle_en, prg_rom_wr, cpu_data, prg_last_bank,
               prg_rom_addr, prg_ram_addr, chr_mem_addr,
        output mmc1_prg_rom_addr, mmc1_prg_ram_addr, mmc1_prg_ram_en,
               mmc1_chr_mem_addr, mmc1_nametable_layout
    );

endinterface

// File: rtl/mapper_mmc1_serial_port.sv
// MMC1 5-bit serial load port: filters RMW double writes, shifts data bit 0
// in LSB-first and emits a one-clk commit (register + value) on the fifth
// write, or a reset strobe on any write with bit 7 set.
module mapper_mmc1_serial_port
    import mapper_mmc1_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cycle_en,
    input  logic       wr,
    input  logic       data_bit0,
    input  logic       data_bit7,
    input  logic [1:0] reg_sel,
    output logic       commit,
    output mmc1_reg_e  commit_reg,
    output logic [4:0] commit_value,
    output logic       reset_strobe
);

    logic       wr_prev;
    logic [3:0] shift;
    logic [2:0] count;
    logic       accept;

    // A write is taken only if the previous CPU cycle was not itself a write.
    assign accept = cycle_en & wr & ~wr_prev;

    // Strobes are valid during the accepting cycle so the top captures on the same edge.
    always_comb begin
        reset_strobe = accept & data_bit7;
        commit       = accept & ~data_bit7 & (count == 3'd4);
        commit_reg   = mmc1_reg_e'(reg_sel);
        commit_value = {data_bit0, shift};
    end

    // Shift state advances only on CPU cycle strobes; fifth write or bit 7 clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_prev <= 1'b0;
            shift   <= 4'd0;
            count   <= 3'd0;
        end else if (cycle_en) begin
            wr_prev <= wr;
            if (accept) begin
                if (data_bit7 || count == 3'd4) begin
                    shift <= 4'd0;
                    count <= 3'd0;
                end else begin
                    shift <= {data_bit0, shift[3:1]};
                    count <= count + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/mapper_mmc1.sv
// MMC1 bank controller: holds control/CHR/PRG bank registers loaded through
// the serial port and translates CPU/PPU addresses combinationally.
module mapper_mmc1
    import mapper_mmc1_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    mapper_mmc1_if.slave  bus
);

    logic       commit;
    mmc1_reg_e  commit_reg;
    logic [4:0] commit_value;
    logic       reset_strobe;

    logic [4:0] control;
    logic [4:0] chr_bank0;
    logic [4:0] chr_bank1;
    logic [4:0] prg_bank;

    prg_mode_e  prg_mode;
    logic [3:0] prg_bank_sel;
    logic       unused_data_bits;

    // Only data bits 0 and 7 have meaning on the serial port.
    assign unused_data_bits = ^bus.cpu_data[6:1];

    mapper_mmc1_serial_port u_serial_port (
        .clk          (clk),
        .rst_n        (rst_n),
        .cycle_en     (bus.cpu_cycle_en),
        .wr           (bus.prg_rom_wr),
        .data_bit0    (bus.cpu_data[0]),
        .data_bit7    (bus.cpu_data[7]),
        .reg_sel      (bus.prg_rom_addr[14:13]),
        .commit       (commit),
        .commit_reg   (commit_reg),
        .commit_value (commit_value),
        .reset_strobe (reset_strobe)
    );

    // Bank registers: loaded on commit; a bit-7 reset forces PRG mode 3 only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            control   <= CONTROL_RESET;
            chr_bank0 <= 5'd0;
            chr_bank1 <= 5'd0;
            prg_bank  <= 5'd0;
        end else if (reset_strobe) begin
            control[3:2] <= 2'b11;
        end else if (commit) begin
            case (commit_reg)
                REG_CONTROL:   control   <= commit_value;
                REG_CHR_BANK0: chr_bank0 <= commit_value;
                REG_CHR_BANK1: chr_bank1 <= commit_value;
                default:       prg_bank  <= commit_value;
            endcase
        end
    end

    // Zero-latency address translation from the current register contents.
    always_comb begin
        prg_mode = prg_mode_e'(control[3:2]);
        case (prg_mode)
            PRG_MODE_FIX_FIRST:
                prg_bank_sel = bus.prg_rom_addr[14] ? prg_bank[3:0] : 4'd0;
            PRG_MODE_FIX_LAST:
                prg_bank_sel = bus.prg_rom_addr[14] ? bus.prg_last_bank : prg_bank[3:0];
            default:
                prg_bank_sel = {prg_bank[3:1], bus.prg_rom_addr[14]};
        endcase
        bus.mmc1_prg_rom_addr = {1'b0, prg_bank_sel, bus.prg_rom_addr[13:0]};

        bus.mmc1_prg_ram_addr = {2'b00, bus.prg_ram_addr};
        bus.mmc1_prg_ram_en   = ~prg_bank[4];

        if (control[4])
            bus.mmc1_chr_mem_addr = {1'b0, (bus.chr_mem_addr[12] ? chr_bank1 : chr_bank0),
                                     bus.chr_mem_addr[11:0]};
        else
            bus.mmc1_chr_mem_addr = {1'b0, chr_bank0[4:1], bus.chr_mem_addr[12:0]};

        bus.mmc1_nametable_layout = layout_from_mirroring(control[1:0]);
    end

endmodule

// File: tb/tb_mapper_mmc1.sv
// Scenario bench for mapper_mmc1: each task drives CPU writes, queues the
// expected translated outputs and pops/compares them once the DUT settles.
module tb_mapper_mmc1;
    import mapper_mmc1_pkg::*;

    typedef struct {
        string       tag;
        logic [18:0] value;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t sb[$];
    exp_t e;
    logic [18:0] got;

    mapper_mmc1_if bus ();

    mapper_mmc1 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // One CPU bus cycle: strobe high for one clk, then two quiet clks.
    task automatic cpu_cycle(input logic wr, input logic [14:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.prg_rom_wr   = wr;
        bus.prg_rom_addr = a;
        bus.cpu_data     = d;
        bus.cpu_cycle_en = 1'b1;
        @(negedge clk);
        bus.cpu_cycle_en = 1'b0;
        bus.prg_rom_wr   = 1'b0;
        @(negedge clk);
    endtask

    // A write followed by an idle CPU cycle so the next write is not filtered.
    task automatic spaced_write(input logic [14:0] a, input logic [7:0] d);
        cpu_cycle(1'b1, a, d);
        cpu_cycle(1'b0, a, 8'h00);
    endtask

    task automatic serial_load(input logic [14:0] a, input logic [4:0] v);
        for (int i = 0; i < 5; i++) spaced_write(a, {7'd0, v[i]});
    endtask

    // Pops the oldest expectation and compares it against the sampled output.
    task automatic test_reset;
        bus.cpu_cycle_en = 1'b0; bus.prg_rom_wr = 1'b0; bus.cpu_data = 8'h00;
        bus.prg_last_bank = 4'hF; bus.prg_rom_addr = 15'h4000;
        bus.prg_ram_addr = 13'h1234; bus.chr_mem_addr = 13'h1ABC;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        sb.push_back('{"rst_prg_c000", 19'h3C000});
        sb.push_back('{"rst_layout", 19'(NAMETABLE_LAYOUT_SINGLE_SCREEN_LOWER)});
        sb.push_back('{"rst_ram_en", 19'd1});
        sb.push_back('{"rst_ram_addr", 19'h01234});
        sb.push_back('{"rst_chr_8k", 19'h01ABC});
        #1;
        e = sb.pop_front(); got = bus.mmc1_prg_rom_addr; tests_run++;
        if (got !== e.value) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.value); end
        else $display("[TB] ok %s %h", e.tag, got);
        e = sb.pop_front(); got = 19'(bus.mmc1_nametable_layout); tests_run++;
        if (got !== e.value) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.value); end
        else $display("[TB] ok %s %h", e.tag, got);
        e = sb.pop_front(); got = 19'(bus.mmc1_prg_ram_en); tests_run++;
        if (got !== e.value) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.value); end
        else $display("[TB] ok %s %h", e.tag, got);
        e = sb.pop_front(); got = 19'(bus.mmc1_prg_ram_addr); tests_run++;
        if (got !== e.value) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.value); end
        else $display("[TB] ok %s %h", e.tag, got);
        e = sb.pop_front(); got = 19'(bus.mmc1_chr_mem_addr); tests_run++;
        if (got !== e.value) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.value); end
        else $display("[TB] ok %s %h", e.tag, got);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_serial_control;
        for (int i = 0; i < 4; i++) spaced_write(15'h0000, (i == 1) ? 8'h01 : 8'h00);
        sb.push_back('{"ctl_after4", 19'(NAMETABLE_LAYOUT_SINGLE_SCREEN_LOWER)});
        #1; e = sb.pop_front(); got = 19'(bus.mmc1_nametable_layout); tests_run++;
        if (got !== e.value) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.value); end
        else $display("[TB] ok %s %h", e.tag, got);
        spaced_write(15'h0000, 8'h00);
        sb.push_back('{"ctl_vertical", 19'(NAMETABLE_LAYOUT_VERTICAL_MIRRORING)});
        #1; e = sb.pop_front(); got = 19'(bus.mmc1_nametable_layout); tests_run++;
        if (got !== e.value) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.value); end
        else $display("[TB] ok %s %h", e.tag, got);
    endtask

    task automatic test_reset_bit7;
        for (int i = 0; i < 3; i++) spaced_write(15'h6000, 8'h01);
        spaced_write(15'h6000, 8'h80);
        for (int i = 0; i < 4; i++) spaced_write(15'h6000, 8'h01);
        sb.push_back('{"prg_ram_en_pending", 19'd1});
        #1; e = sb.pop_front(); got = 19'(bus.mmc1_prg_ram_en); tests_run++;
        if (got !== e.value) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.value); end
        else $display("[TB] ok %s %h", e.tag, got);
        spaced_write(15'h6000, 8'h01);
        bus.prg_last_bank = 4'h7;
        bus.prg_rom_addr = 15'h0000;
        sb.push_back('{"prg_ram_en_off", 19'd0});
        sb.push_back('{"prg1f_8000", 19'h3C000});
        sb.push_back('{"b7_keeps_mirror", 19'(NAMETABLE_LAYOUT_VERTICAL_MIRRORING)});
        #1; e = sb.pop_front(); got = 19'(bus.mmc1_prg_ram_en); tests_run++;
        if (got !== e.value) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.value); end
        else $display("[TB] ok %s %h", e.tag, got);
        e = sb.pop_front(); got = bus.mmc1_prg_rom_addr; tests_run++;
        if (got !== e.value) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.value); end
        else $display("[TB] ok %s %h", e.tag, got);
        e = sb.pop_front(); got = 19'(bus.mmc1_nametable_layout); tests_run++;
        if (got !== e.value) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.value); end
        else $display("[TB] ok %s %h", e.tag, got);
        bus.prg_rom_addr = 15'h4010;
        sb.push_back('{"mode3_last7_c010", 19'h1C010});
        #1; e = sb.pop_front(); got = bus.mmc1_prg_rom_addr; tests_run++;
        if (got !== e.value) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.value); end
        else $display("[TB] ok %s %h", e.tag, got);
        bus.prg_last_bank = 4'hF;
    endtask

    task automatic test_back_to_back;
        // chr_bank0 target bits 1,0,1,0,0 with an RMW double write and en-less writes mixed in.
        cpu_cycle(1'b1, 15'h2000, 8'h01);
        cpu_cycle(1'b1, 15'h2000, 8'h01);
        cpu_cycle(1'b0, 15'h2000, 8'h00);
        @(negedge clk);
        bus.prg_rom_wr = 1'b1; bus.cpu_data = 8'h01; bus.prg_rom_addr = 15'h2000;
        repeat (3) @(negedge clk);
        bus.prg_rom_wr = 1'b0;
        spaced_write(15'h2000, 8'h00);
        spaced_write(15'h2000, 8'h01);
        spaced_write(15'h2000, 8'h00);
        bus.chr_mem_addr = 13'h0123;
        sb.push_back('{"b2b_no_commit_yet", 19'h00123});
        #1; e = sb.pop_front(); got = 19'(bus.mmc1_chr_mem_addr); tests_run++;
        if (got !== e.value) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.value); end
        else $display("[TB] ok %s %h", e.tag, got);
        spaced_write(15'h2000, 8'h00);
        sb.push_back('{"b2b_chr8k", 19'h04123});
        #1; e = sb.pop_front(); got = 19'(bus.mmc1_chr_mem_addr); tests_run++;
        if (got !== e.value) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.value); end
        else $display("[TB] ok %s %h", e.tag, got);
        serial_load(15'h4000, 5'd9);
        serial_load(15'h0000, 5'h10);
        sb.push_back('{"chr4k_lo", 19'h05123});
        sb.push_back('{"chr4k_hi", 19'h09123});
        sb.push_back('{"mode0_8000", 19'h38000});
        sb.push_back('{"mode0_c000", 19'h3C000});
        bus.chr_mem_addr = 13'h0123;
        #1; e = sb.pop_front(); got = 19'(bus.mmc1_chr_mem_addr); tests_run++;
        if (got !== e.value) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.value); end
        else $display("[TB] ok %s %h", e.tag, got);
        bus.chr_mem_addr = 13'h1123;
        #1; e = sb.pop_front(); got = 19'(bus.mmc1_chr_mem_addr); tests_run++;
        if (got !== e.value) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.value); end
        else $display("[TB] ok %s %h", e.tag, got);
        bus.prg_rom_addr = 15'h0000;
        #1; e = sb.pop_front(); got = bus.mmc1_prg_rom_addr; tests_run++;
        if (got !== e.value) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.value); end
        else $display("[TB] ok %s %h", e.tag, got);
        bus.prg_rom_addr = 15'h4000;
        #1; e = sb.pop_front(); got = bus.mmc1_prg_rom_addr; tests_run++;
        if (got !== e.value) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.value); end
        else $display("[TB] ok %s %h", e.tag, got);
    endtask

    task automatic test_prg_mode2;
        serial_load(15'h0000, 5'b01000);
        serial_load(15'h6000, 5'd3);
        sb.push_back('{"mode2_8000", 19'h00000});
        sb.push_back('{"mode2_c005", 19'h0C005});
        bus.prg_rom_addr = 15'h0000;
        #1; e = sb.pop_front(); got = bus.mmc1_prg_rom_addr; tests_run++;
        if (got !== e.value) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.value); end
        else $display("[TB] ok %s %h", e.tag, got);
        bus.prg_rom_addr = 15'h4005;
        #1; e = sb.pop_front(); got = bus.mmc1_prg_rom_addr; tests_run++;
        if (got !== e.value) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.value); end
        else $display("[TB] ok %s %h", e.tag, got);
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++) spaced_write(15'h0000, 8'h01);
        #2 rst_n = 1'b0;
        bus.prg_rom_addr = 15'h4000;
        sb.push_back('{"async_rst_prg", 19'h3C000});
        #1; e = sb.pop_front(); got = bus.mmc1_prg_rom_addr; tests_run++;
        if (got !== e.value) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.value); end
        else $display("[TB] ok %s %h", e.tag, got);
        @(negedge clk);
        rst_n = 1'b1;
        spaced_write(15'h0000, 8'h00);
        spaced_write(15'h0000, 8'h01);
        sb.push_back('{"rst_discards_shift", 19'(NAMETABLE_LAYOUT_SINGLE_SCREEN_LOWER)});
        #1; e = sb.pop_front(); got = 19'(bus.mmc1_nametable_layout); tests_run++;
        if (got !== e.value) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.value); end
        else $display("[TB] ok %s %h", e.tag, got);
        for (int i = 0; i < 3; i++) spaced_write(15'h0000, 8'h00);
        sb.push_back('{"post_rst_vertical", 19'(NAMETABLE_LAYOUT_VERTICAL_MIRRORING)});
        #1; e = sb.pop_front(); got = 19'(bus.mmc1_nametable_layout); tests_run++;
        if (got !== e.value) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.value); end
        else $display("[TB] ok %s %h", e.tag, got);
    endtask

    task automatic test_bit7_fifth;
        for (int i = 0; i < 4; i++) spaced_write(15'h0000, 8'h01);
        spaced_write(15'h0000, 8'h81);
        bus.prg_rom_addr = 15'h4000;
        sb.push_back('{"b7_fifth_no_commit", 19'(NAMETABLE_LAYOUT_VERTICAL_MIRRORING)});
        sb.push_back('{"b7_fifth_mode3", 19'h3C000});
        #1; e = sb.pop_front(); got = 19'(bus.mmc1_nametable_layout); tests_run++;
        if (got !== e.value) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.value); end
        else $display("[TB] ok %s %h", e.tag, got);
        e = sb.pop_front(); got = bus.mmc1_prg_rom_addr; tests_run++;
        if (got !== e.value) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.value); end
        else $display("[TB] ok %s %h", e.tag, got);
        serial_load(15'h0000, 5'b00001);
        sb.push_back('{"fresh_load_upper", 19'(NAMETABLE_LAYOUT_SINGLE_SCREEN_UPPER)});
        #1; e = sb.pop_front(); got = 19'(bus.mmc1_nametable_layout); tests_run++;
        if (got !== e.value) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.value); end
        else $display("[TB] ok %s %h", e.tag, got);
    endtask

    initial begin
        test_reset();
        test_serial_control();
        test_reset_bit7();
        test_back_to_back();
        test_prg_mode2();
        test_reset_mid();
        test_bit7_fifth();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
